direction_input: RTL and testbench
==================================

DIRECTION_INPUT -- requirements
Module: direction_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive cycles a synchronized button level must differ from its debounced level before the debounced level flips.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, cycles a command is driven on direction.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btn_n  input  4  raw asynchronous buttons, active-low; bit0 top, bit1 bottom, bit2 left, bit3 right.
REQ-006 SHALL have port enable  input  1  high while the game accepts moves.
REQ-007 SHALL have port direction  output  4  one-hot move command to the game: 0001 top, 0010 bottom, 0100 left, 1000 right, 0000 none.
REQ-008 SHALL have port pressed  output  4  debounced button levels, active-high.
REQ-009 SHALL have port busy  output  1  high in ISSUE and WAIT_RELEASE.

Function
REQ-010 SHALL pass each btn_n bit through a two-flop synchronizer before debouncing.
REQ-011 SHALL, per button, count cycles where the synchronized level differs from the debounced level, clear the count when they match, and flip the debounced level on the edge where the count would reach DEBOUNCE_CYCLES.
REQ-012 SHALL size debounce counters to $clog2(DEBOUNCE_CYCLES+1) bits, saturating, never wrapping.
REQ-013 SHALL implement FSM states ARMED, ISSUE, WAIT_RELEASE.
REQ-014 In ARMED with enable=1 and exactly one pressed bit set, SHALL latch that one-hot value, drive it on direction from the next edge, load the hold counter and enter ISSUE.
REQ-015 In ARMED with two or more pressed bits set, SHALL issue no command and enter WAIT_RELEASE.
REQ-016 In ARMED with enable=0, SHALL issue no command and stay in ARMED.
REQ-017 In ISSUE, SHALL hold direction constant for exactly HOLD_CYCLES cycles regardless of button or enable changes, then drive 0000 and enter WAIT_RELEASE.
REQ-018 In WAIT_RELEASE, SHALL keep direction at 0000 and enter ARMED on the edge after pressed becomes 0000.
REQ-019 SHALL emit at most one command per press; a held button never repeats.
REQ-020 SHALL, with HOLD_CYCLES=0, behave as HOLD_CYCLES=1.
REQ-021 SHALL keep direction either 0000 or exactly one bit set at all times.
REQ-022 Latency: a clean press SHALL assert direction DEBOUNCE_CYCLES+3 rising edges after btn_n is first sampled low.

Reset
REQ-023 On rst=1 at a rising edge, SHALL set synchronizer flops to 1, debounced levels to released, counters to 0, state ARMED, direction=0000, pressed=0000, busy=0.
REQ-024 Reset during ISSUE SHALL force direction to 0000 on that edge; a button still held after reset SHALL produce a new command after full debounce.

Structure
REQ-025 SHALL take direction one-hot constants and the FSM state enum from shared package game2048_pkg.
REQ-026 SHALL instantiate one sub-module, debounce, four times (synchronizer plus counter per button).

Verification
Bench uses DEBOUNCE_CYCLES=4, HOLD_CYCLES=3.
REQ-027 Press btn_n[2] low for 20 cycles -> direction=0100 for exactly 3 cycles starting 7 edges after first low sample, then 0000; no repeat while held.
REQ-028 Glitch btn_n[0] low for 3 cycles then high -> pressed stays 0000, direction stays 0000.
REQ-029 btn_n[1] and btn_n[3] low together for 20 cycles -> direction stays 0000, busy=1 until both are released.
REQ-030 Press btn_n[3] with enable=0 for 20 cycles, then raise enable -> direction=1000 for 3 cycles within 1 cycle of enable rising.
REQ-031 rst=1 during the second ISSUE cycle with btn_n[0] held -> direction=0000 on that edge; after release of rst, direction=0001 again 7 edges later.
REQ-032 Release btn_n[2] and press it again after command completes -> second 0100 command of 3 cycles; pressing during WAIT_RELEASE before release is debounced yields no command.

Source files
------------

// File: rtl/game2048_pkg.sv
// Shared 2048-game definitions: move-command encodings, input FSM states and
// a helper that recognises a legal single-direction command.
package game2048_pkg;

  typedef enum logic [1:0] {
    ARMED        = 2'd0,
    ISSUE        = 2'd1,
    WAIT_RELEASE = 2'd2
  } dir_state_t;

  localparam logic [3:0] DIR_NONE   = 4'b0000;
  localparam logic [3:0] DIR_TOP    = 4'b0001;
  localparam logic [3:0] DIR_BOTTOM = 4'b0010;
  localparam logic [3:0] DIR_LEFT   = 4'b0100;
  localparam logic [3:0] DIR_RIGHT  = 4'b1000;

  // True only for exactly one button / one direction bit set.
  function automatic logic is_direction(input logic [3:0] v);
    case (v)
      DIR_TOP, DIR_BOTTOM, DIR_LEFT, DIR_RIGHT: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/debounce.sv
// One button: two-flop synchronizer on the raw active-low input followed by a
// saturating disagreement counter that flips the debounced level.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE_CYCLES < 1) ? 0 : DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter on the asynchronous button
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
      // debounce stage: the flip happens on the edge whose count would reach DEBOUNCE_CYCLES
      if (~sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pressed = level;

endmodule

// File: rtl/direction_input.sv
// Turns four raw buttons into single, fixed-length one-hot move commands,
// one command per press, suppressed for chords and while the game is disabled.
module direction_input
  import game2048_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  input  logic       enable,
  output logic [3:0] direction,
  output logic [3:0] pressed,
  output logic       busy
);

  localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int HW       = (HOLD_EFF < 2) ? 1 : $clog2(HOLD_EFF);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_EFF - 1);

  dir_state_t    state, state_nxt;
  logic [3:0]    dir_q, dir_nxt;
  logic [HW-1:0] hold_q, hold_nxt;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_n  (btn_n[i]),
      .pressed(pressed[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARMED;
      dir_q  <= DIR_NONE;
      hold_q <= '0;
    end else begin
      state  <= state_nxt;
      dir_q  <= dir_nxt;
      hold_q <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir_q;
    hold_nxt  = hold_q;
    case (state)
      ARMED: begin
        if (enable) begin
          if (is_direction(pressed)) begin
            dir_nxt   = pressed;
            hold_nxt  = HOLD_LOAD;
            state_nxt = ISSUE;
          end else if (pressed != DIR_NONE) begin
            state_nxt = WAIT_RELEASE;
          end
        end
      end
      ISSUE: begin
        // hold_q counts the remaining cycles after the current one
        if (hold_q == '0) begin
          dir_nxt   = DIR_NONE;
          state_nxt = WAIT_RELEASE;
        end else begin
          hold_nxt = hold_q - 1'b1;
        end
      end
      WAIT_RELEASE: begin
        dir_nxt = DIR_NONE;
        if (pressed == DIR_NONE) state_nxt = ARMED;
      end
      default: begin
        dir_nxt   = DIR_NONE;
        state_nxt = ARMED;
      end
    endcase
  end

  assign direction = dir_q;
  assign busy      = (state != ARMED);

endmodule

// File: tb/tb_direction_input.sv
// Directed bench for direction_input with short debounce and hold times.
module tb_direction_input;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_n;
  logic       enable;
  logic [3:0] direction;
  logic [3:0] pressed;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  direction_input #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .enable   (enable),
    .direction(direction),
    .pressed  (pressed),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_n  = 4'hF;
    enable = 1'b1;
    tick();
    tick();
    check("rst_direction", direction, 4'h0);
    check("rst_pressed", pressed, 4'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Left press: command 7 edges after first low sample, 3 cycles long
    btn_n = 4'b1011;
    repeat (6) tick();
    check("left_before", direction, 4'h0);
    tick();
    check("left_edge7", direction, 4'b0100);
    check("left_busy", busy, 1'b1);
    check("left_pressed", pressed, 4'b0100);
    tick();
    check("left_edge8", direction, 4'b0100);
    tick();
    check("left_edge9", direction, 4'b0100);
    tick();
    check("left_edge10", direction, 4'h0);
    for (int i = 11; i <= 20; i++) begin
      tick();
      check("left_no_repeat", direction, 4'h0);
    end

    // Brief release while in WAIT_RELEASE is filtered: no new command
    btn_n = 4'hF;
    tick();
    tick();
    btn_n = 4'b1011;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("bounce_dir", direction, 4'h0);
      check("bounce_pressed", pressed, 4'b0100);
    end
    btn_n = 4'hF;
    repeat (10) tick();
    check("left_released", pressed, 4'h0);
    check("left_idle", busy, 1'b0);

    // Second left press after completion gives a second command
    btn_n = 4'b1011;
    repeat (6) tick();
    check("left2_before", direction, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("left2_active", direction, 4'b0100);
    end
    tick();
    check("left2_end", direction, 4'h0);
    btn_n = 4'hF;
    repeat (10) tick();

    // Glitch on top button shorter than the debounce window
    btn_n = 4'b1110;
    repeat (3) tick();
    btn_n = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("glitch_pressed", pressed, 4'h0);
      check("glitch_dir", direction, 4'h0);
    end

    // Chord: bottom + right together never issues
    btn_n = 4'b0101;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("chord_dir", direction, 4'h0);
    end
    check("chord_pressed", pressed, 4'b1010);
    check("chord_busy", busy, 1'b1);
    btn_n = 4'hF;
    repeat (6) tick();
    check("chord_release_pressed", pressed, 4'h0);
    check("chord_busy_held", busy, 1'b1);
    tick();
    check("chord_busy_clear", busy, 1'b0);
    repeat (3) tick();

    // Right held while disabled, then enable rises
    enable = 1'b0;
    btn_n  = 4'b0111;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("dis_dir", direction, 4'h0);
    end
    check("dis_busy", busy, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_active", direction, 4'b1000);
    end
    tick();
    check("en_end", direction, 4'h0);
    btn_n = 4'hF;
    repeat (10) tick();

    // Reset in the second ISSUE cycle with top held
    btn_n = 4'b1110;
    repeat (7) tick();
    check("rst_issue1", direction, 4'b0001);
    tick();
    check("rst_issue2", direction, 4'b0001);
    rst = 1'b1;
    tick();
    check("rst_mid_dir", direction, 4'h0);
    check("rst_mid_pressed", pressed, 4'h0);
    check("rst_mid_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (6) tick();
    check("post_rst_before", direction, 4'h0);
    tick();
    check("post_rst_cmd", direction, 4'b0001);
    btn_n = 4'hF;
    repeat (12) tick();
    check("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Direction must never carry more than one bit at a sampled point
  always @(negedge clk) begin
    if (!rst && direction != 4'h0) begin
      if ((direction & (direction - 4'd1)) != 4'h0) begin
        check("dir_onehot", direction, 4'h0);
      end
    end
  end

endmodule
